// File: rtl/autocomplete_pkg.sv
// ============================================================================
// autocomplete_pkg : keyword ROM, status/state encodings and ROM helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package autocomplete_pkg;

  localparam int KW_TABLE_SIZE = 8;
  localparam int KW_MAX_LEN    = 8;

  localparam logic [7:0] ESC    = 8'd27;
  localparam logic [7:0] CSI_BR = 8'd91;

  typedef enum logic [1:0] {
    ST_NONE   = 2'd0,
    ST_UNIQUE = 2'd1,
    ST_AMBIG  = 2'd2,
    ST_CSI    = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_RESOLVE = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Keywords are left-aligned: the first character sits in the top byte.
  localparam logic [KW_TABLE_SIZE-1:0][8*KW_MAX_LEN-1:0] KW = {
    64'h0, 64'h0, 64'h0, 64'h0,
    {"lsblk", 24'h0},
    {"ls", 48'h0},
    "uname -a",
    {"clear", 24'h0}
  };

  localparam logic [KW_TABLE_SIZE-1:0][3:0] KW_LEN = {
    4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd2, 4'd8, 4'd5
  };

  function automatic logic [7:0] kw_char(input logic [2:0] c, input int unsigned i);
    logic [8*KW_MAX_LEN-1:0] s;
    s = KW[c] << (8 * i);
    return s[8*KW_MAX_LEN-1 -: 8];
  endfunction

  function automatic int unsigned kw_len(input logic [2:0] c);
    return 32'(KW_LEN[c]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/autocomplete_engine_if.sv
// ============================================================================
// autocomplete_engine_if : line-buffer read port, control and output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface autocomplete_engine_if #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MATCH_W = 2
);
  logic               start;
  logic [ADDR_W-1:0]  len;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  in_data;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic [1:0]         status;
  logic [MATCH_W-1:0] match_idx;

  modport master (
    output start, len, in_data, out_ready,
    input  addr, out_data, out_valid, busy, done, status, match_idx
  );

  modport slave (
    input  start, len, in_data, out_ready,
    output addr, out_data, out_valid, busy, done, status, match_idx
  );
endinterface

`default_nettype wire

// File: rtl/autocomplete_engine_kw_match_lane.sv
// ============================================================================
// kw_match_lane : next candidate-mask bit for one keyword-table entry
// Rev 1.0
// ============================================================================
`default_nettype none

module kw_match_lane
  import autocomplete_pkg::*;
#(
  parameter int IDX    = 0,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              mask_i,
  output logic              mask_o
);

  logic in_range;
  logic char_eq;

  assign in_range = 32'(addr_i) < kw_len(3'(IDX));
  assign char_eq  = in_i == DATA_W'(kw_char(3'(IDX), 32'(addr_i)));
  assign mask_o   = mask_i & in_range & char_eq;

endmodule

`default_nettype wire

// File: rtl/autocomplete_engine.sv
// ============================================================================
// autocomplete_engine : prefix scan, candidate resolve and completion stream
// Optional macro AUTOCOMP_LCP_EN emits the common prefix on ambiguity. Rev 1.0
// ============================================================================
`default_nettype none

module autocomplete_engine
  import autocomplete_pkg::*;
#(
  parameter int NUM_CMDS = 4,
  parameter int MAX_LEN  = 8,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8
) (
  input logic clk,
  input logic rst_n,
  autocomplete_engine_if.slave ac_if
);

  localparam int MATCH_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, len_q, len_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d, end_q, end_d;
  logic [NUM_CMDS-1:0] mask_q, mask_d, mask_scan;
  logic [MATCH_W-1:0]  idx_q, idx_d, first_idx;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                ovalid_q, ovalid_d, busy_q, busy_d;
  logic [ADDR_W-1:0]   len_in;
  int unsigned         pop;

  function automatic logic [DATA_W-1:0] char_at(input logic [MATCH_W-1:0] idx,
                                                input logic [ADDR_W-1:0] pos);
    return DATA_W'(kw_char(3'(idx), 32'(pos)));
  endfunction

  assign len_in = (32'(ac_if.len) > 32'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : ac_if.len;

  for (genvar g = 0; g < NUM_CMDS; g++) begin : g_lane
    kw_match_lane #(
      .IDX    (g),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_lane (
      .addr_i (addr_q),
      .in_i   (ac_if.in_data),
      .mask_i (mask_q[g]),
      .mask_o (mask_scan[g])
    );
  end

  // Descending walk leaves first_idx on the lowest surviving entry.
  always_comb begin
    pop       = 0;
    first_idx = '0;
    for (int c = NUM_CMDS - 1; c >= 0; c--) begin
      if (mask_q[c]) begin
        pop       = pop + 1;
        first_idx = MATCH_W'(c);
      end
    end
  end

`ifdef AUTOCOMP_LCP_EN
  int unsigned lcp;

  always_comb begin
    lcp = kw_len(3'(first_idx));
    for (int c = 0; c < NUM_CMDS; c++) begin
      for (int unsigned i = 0; i < KW_MAX_LEN; i++) begin
        if (mask_q[c] && (i < lcp) &&
            ((i >= kw_len(3'(c))) || (kw_char(3'(c), i) != kw_char(3'(first_idx), i)))) begin
          lcp = i;
        end
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    addr_d   = addr_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    end_d    = end_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (ac_if.start) begin
          addr_d   = '0;
          mask_d   = '1;
          len_d    = len_in;
          busy_d   = 1'b1;
          status_d = ST_NONE;
          state_d  = (len_in == '0) ? S_RESOLVE : S_SCAN;
        end
      end
      S_SCAN: begin
        if ((addr_q == '0) && (ac_if.in_data == DATA_W'(ESC))) begin
          status_d = ST_CSI;
          ptr_d    = '0;
          end_d    = ADDR_W'(1);
          odata_d  = DATA_W'(CSI_BR);
          ovalid_d = 1'b1;
          state_d  = S_EMIT;
        end else begin
          mask_d = mask_scan;
          addr_d = addr_q + 1'b1;
          if (addr_q == len_q - 1'b1) state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (pop == 0) begin
          status_d = ST_NONE;
          state_d  = S_DONE;
        end else if (pop == 1) begin
          status_d = ST_UNIQUE;
          idx_d    = first_idx;
          ptr_d    = len_q;
          end_d    = ADDR_W'(kw_len(3'(first_idx)));
          if (32'(len_q) >= kw_len(3'(first_idx))) begin
            state_d = S_DONE;
          end else begin
            odata_d  = char_at(first_idx, len_q);
            ovalid_d = 1'b1;
            state_d  = S_EMIT;
          end
        end else begin
          status_d = ST_AMBIG;
          state_d  = S_DONE;
`ifdef AUTOCOMP_LCP_EN
          if (lcp > 32'(len_q)) begin
            idx_d    = first_idx;
            ptr_d    = len_q;
            end_d    = ADDR_W'(lcp);
            odata_d  = char_at(first_idx, len_q);
            ovalid_d = 1'b1;
            state_d  = S_EMIT;
          end
`endif
        end
      end
      S_EMIT: begin
        if (ovalid_q && ac_if.out_ready) begin
          if ((ptr_q + 1'b1) == end_q) begin
            ovalid_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            odata_d = char_at(idx_q, ptr_q + 1'b1);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      status_q <= ST_NONE;
      addr_q   <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      end_q    <= '0;
      mask_q   <= '1;
      idx_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      end_q    <= end_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
    end
  end

  assign ac_if.addr      = addr_q;
  assign ac_if.out_data  = odata_q;
  assign ac_if.out_valid = ovalid_q;
  assign ac_if.busy      = busy_q;
  assign ac_if.done      = (state_q == S_DONE);
  assign ac_if.status    = status_q;
  assign ac_if.match_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_autocomplete_engine.sv
// ============================================================================
// tb_autocomplete_engine : directed self-checking bench for autocomplete_engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_autocomplete_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] lbuf [32];

  autocomplete_engine_if #(.ADDR_W(5), .DATA_W(8), .MATCH_W(2)) ac ();

  autocomplete_engine #(
    .NUM_CMDS (4),
    .MAX_LEN  (8),
    .ADDR_W   (5),
    .DATA_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ac_if (ac)
  );

  assign ac.in_data = lbuf[ac.addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 32; i++) lbuf[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) lbuf[i] = s[i];
  endtask

  // mode 0: ready high, 1: ready toggles, 2: ready high and start held during the op
  task automatic run_op(input string tag, input logic [4:0] l, input string exp,
                        input logic [1:0] exp_st, input logic [1:0] exp_idx, input int mode);
    logic [7:0] got [$];
    int         cyc [$];
    bit         seen_done;
    int         done_cyc;
    bit         hold_v;
    logic [7:0] hold_d;
    seen_done = 0;
    done_cyc  = 0;
    hold_v    = 0;
    hold_d    = 8'h00;
    ac.start  = 1'b1;
    ac.len    = l;
    @(posedge clk); #1;
    if (mode != 2) ac.start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      ac.out_ready = (mode == 1) ? n[0] : 1'b1;
      if (hold_v) chk({tag, "_hold"}, {23'd0, ac.out_valid, ac.out_data}, {23'd0, 1'b1, hold_d});
      hold_v = 0;
      if (ac.done) begin
        seen_done = 1;
        done_cyc  = n;
        break;
      end
      if (ac.out_valid && ac.out_ready) begin
        got.push_back(ac.out_data);
        cyc.push_back(n);
      end else if (ac.out_valid) begin
        hold_v = 1;
        hold_d = ac.out_data;
      end
      @(posedge clk); #1;
    end
    ac.start     = 1'b0;
    ac.out_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, "_nbytes"}, got.size(), exp.len());
    for (int i = 0; i < got.size() && i < exp.len(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    chk({tag, "_status"}, 32'(ac.status), 32'(exp_st));
    if (exp_st == 2'd1) chk({tag, "_idx"}, 32'(ac.match_idx), 32'(exp_idx));
    if (mode == 0 && got.size() > 0) begin
      chk({tag, "_back2back"}, cyc[cyc.size()-1] - cyc[0], got.size() - 1);
      chk({tag, "_done_lat"}, done_cyc, cyc[cyc.size()-1] + 1);
    end
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, 32'(ac.busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(ac.done), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    ac.start     = 1'b0;
    ac.len       = '0;
    ac.out_ready = 1'b1;
    load("");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr",      32'(ac.addr),      32'd0);
    chk("rst_out_data",  32'(ac.out_data),  32'd0);
    chk("rst_out_valid", 32'(ac.out_valid), 32'd0);
    chk("rst_busy",      32'(ac.busy),      32'd0);
    chk("rst_done",      32'(ac.done),      32'd0);
    chk("rst_status",    32'(ac.status),    32'd0);
    chk("rst_match_idx", 32'(ac.match_idx), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    load("cl");         run_op("cl",    5'd2, "ear",     2'd1, 2'd0, 0);
    load("u");          run_op("u_bp",  5'd1, "name -a", 2'd1, 2'd1, 1);
    load("u");          run_op("u",     5'd1, "name -a", 2'd1, 2'd1, 0);
    load("\033abc");    run_op("esc",   5'd3, "[",       2'd3, 2'd0, 0);
    load("xz");         run_op("xz",    5'd2, "",        2'd0, 2'd0, 0);
    load("clear");      run_op("clear", 5'd5, "",        2'd1, 2'd0, 0);
`ifdef AUTOCOMP_LCP_EN
    load("l");          run_op("l",     5'd1, "s",       2'd2, 2'd0, 0);
`else
    load("l");          run_op("l",     5'd1, "",        2'd2, 2'd0, 0);
`endif
    load("");           run_op("len0",  5'd0, "",        2'd2, 2'd0, 0);
    load("ls");         run_op("ls",    5'd2, "",        2'd2, 2'd0, 0);
    load("lsb");        run_op("lsb_busy", 5'd3, "lk",   2'd1, 2'd3, 2);
    load("uname -a!!"); run_op("clamp", 5'd20, "",       2'd1, 2'd1, 0);
    load("lsblkx");     run_op("short", 5'd6, "",        2'd0, 2'd0, 0);

    // Reset while the second completion character of "ear" is pending
    load("cl");
    ac.start = 1'b1;
    ac.len   = 5'd2;
    @(posedge clk); #1;
    ac.start = 1'b0;
    for (int k = 0; k < 20 && !ac.out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_first", 32'(ac.out_data), 32'd101);
    @(posedge clk); #1;
    chk("rst_mid_second", 32'(ac.out_data), 32'd97);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",  32'(ac.out_valid), 32'd0);
    chk("rst_mid_busy",   32'(ac.busy),      32'd0);
    chk("rst_mid_status", 32'(ac.status),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 5'd2, "ear", 2'd1, 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/autocomplete_engine.md
Name: autocomplete_engine

Overview:
- Parametrised command-line completer for the terminal front end.
- On a start pulse it scans the typed prefix from the line buffer and narrows a keyword table to its candidates.
- It then streams the missing completion characters out on a valid/ready byte stream.
- It also recognises a leading ESC and answers with the CSI '[' byte. Sits between the line buffer and the terminal TX path.

Parameters:
- NUM_CMDS, 4, number of keyword-table entries used (1..KW_TABLE_SIZE).
- MAX_LEN, 8, maximum keyword length in characters.
- ADDR_W, 5, line-buffer address width; must satisfy 2**ADDR_W > MAX_LEN.
- DATA_W, 8, character width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy=1.
- len  in  ADDR_W  number of typed characters; sampled when start is accepted.
- addr  out  ADDR_W  line-buffer read address.
- in  in  DATA_W  line-buffer data for the current addr (combinational read, same cycle).
- out_data  out  DATA_W  completion character.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high from start acceptance until the cycle after done.
- done  out  1  one-cycle pulse at the end of the operation.
- status  out  2  result: 0=NONE, 1=UNIQUE, 2=AMBIG, 3=CSI. Held until the next start.
- match_idx  out  $clog2(NUM_CMDS) (min 1)  matched entry; valid when status=UNIQUE.

Behaviour:
- Reset values: addr=0, out_data=0, out_valid=0, busy=0, done=0, status=NONE, match_idx=0, state=IDLE, candidate mask=all ones. Reset mid-operation aborts immediately; any pending character is dropped.
- IDLE: start=1 -> addr<=0, mask<=all ones, latch len, busy<=1. Next state is SCAN, or RESOLVE if len=0.
- SCAN: one character per cycle.
  - If addr=0 and in=27: status<=CSI and go to EMIT; the only character emitted is 91 ('[').
  - Otherwise, for each entry c: mask[c] &= (addr < kwlen[c]) && (kw[c][addr] == in).
  - addr increments each cycle; when addr=len-1, go to RESOLVE.
- RESOLVE (1 cycle):
  - popcount(mask)=0 -> status NONE, go to DONE.
  - popcount=1 -> status UNIQUE, match_idx=index, emit pointer=len. Go to EMIT, or directly to DONE if len=kwlen (exact match, nothing to emit).
  - popcount>1 -> status AMBIG; behaviour set by the optional feature.
- EMIT: out_data=kw[match_idx][ptr] with out_valid=1.
  - out_data and out_valid are held stable until out_ready=1.
  - On each transfer, ptr++. After the transfer of character kwlen-1, go to DONE.
  - Throughput is 1 character per cycle when out_ready is held high.
- DONE: done=1 for one cycle, busy<=0, go to IDLE. start is accepted again on the following cycle.
- Boundaries:
  - len > MAX_LEN is clamped to MAX_LEN.
  - Entries shorter than the prefix are eliminated.
  - start while busy is ignored.
  - Entries with index >= NUM_CMDS are never candidates.

Optional Feature:
- Macro AUTOCOMP_LCP_EN.
- Defined: on AMBIG, emit the longest common prefix of all remaining candidates beyond len, using the same EMIT handshake; zero characters if that prefix is empty. status stays AMBIG.
- Undefined: AMBIG goes straight to DONE with no characters emitted.

Decomposition:
- Package autocomplete_pkg holds:
  - KW_TABLE_SIZE=8 and the keyword ROM constants kw[KW_TABLE_SIZE][MAX_LEN] and kwlen[].
  - Default table: "clear", "uname -a", "ls", "lsblk".
  - Status enum {ST_NONE, ST_UNIQUE, ST_AMBIG, ST_CSI}.
  - Character constants ESC=27, CSI_BR=91.
- One sub-module, kw_match_lane: per-entry mask bit update (compare and length check), instantiated NUM_CMDS times via generate.

Test Plan:
- Buffer "cl", len=2, out_ready=1 -> bytes 101, 97, 114 ("ear") on consecutive cycles; status=UNIQUE, match_idx=0, done one cycle after the last byte.
- Buffer "u", len=1 -> "name -a" (110, 97, 109, 101, 32, 45, 97); then check backpressure: toggle out_ready 1/0 and confirm out_data is held stable and no character is lost.
- Buffer[0]=27, len=3 -> single byte 91; status=CSI.
- Buffer "xz", len=2 -> no out_valid; status=NONE. Buffer "clear", len=5 -> status=UNIQUE, zero characters emitted.
- Buffer "l", len=1 -> with AUTOCOMP_LCP_EN: byte 115 ('s'), status=AMBIG. Without the macro: no output, status=AMBIG. Buffer len=0 -> AMBIG with no output in both builds.
- Assert rst_n low during EMIT of "ear" after the first byte -> out_valid=0, busy=0, status=NONE immediately; a new start then completes normally.
